// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port SRAM controller among three requesters: instruction
// fetch (i), load/store unit (d) and the on-chip debugger (dbg). The debugger
// always wins. Fetch and load/store alternate round-robin when both are
// pending. The block remembers who owns the one outstanding read and steers
// the read acknowledge to that requester. If the controller never returns
// an ack, the read is forced to complete after RD_TIMEOUT cycles.
//
// Parameters
//   RD_TIMEOUT  cycles an outstanding read may wait for mem_read_ack (1..15)
//   RR_INIT     round-robin pointer after reset (0 = i preferred, 1 = d)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   sync_reset            synchronous active-high reset, same effect as reset_n
//   i_addr/i_re           fetch request        -> i_gnt, i_rd_ack
//   d_addr/d_we/d_wdata/d_re
//                         load/store request   -> d_gnt, d_rd_ack
//   dbg_addr/dbg_we/dbg_wdata/dbg_re
//                         debugger request     -> dbg_gnt, dbg_rd_ack
//   rd_data               shared read-data return bus (0 when no ack)
//   mem_addr/mem_write_en/mem_write_data/mem_read_en
//                         command to the memory controller (winner's request)
//   mem_read_data/mem_read_ack
//                         read return, ack one cycle after mem_read_en
//   timeout_err           sticky: a read was force-completed
// -----------------------------------------------------------------------------

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_BYTES
`define XLEN_BYTES 4
`endif

// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no read outstanding, grants allowed
// ST_READ | one read outstanding, waiting for mem_read_ack or timeout
module mem_arbiter #(
    parameter int   RD_TIMEOUT = 4,
    parameter logic RR_INIT    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sync_reset,

    input  logic [`MEM_ADDR_BITS-1:0] i_addr,
    input  logic                      i_re,
    output logic                      i_gnt,
    output logic                      i_rd_ack,

    input  logic [`MEM_ADDR_BITS-1:0] d_addr,
    input  logic [`XLEN_BYTES-1:0]    d_we,
    input  logic [`XLEN-1:0]          d_wdata,
    input  logic                      d_re,
    output logic                      d_gnt,
    output logic                      d_rd_ack,

    input  logic [`MEM_ADDR_BITS-1:0] dbg_addr,
    input  logic [`XLEN_BYTES-1:0]    dbg_we,
    input  logic [`XLEN-1:0]          dbg_wdata,
    input  logic                      dbg_re,
    output logic                      dbg_gnt,
    output logic                      dbg_rd_ack,

    output logic [`XLEN-1:0]          rd_data,

    output logic [`MEM_ADDR_BITS-1:0] mem_addr,
    output logic [`XLEN_BYTES-1:0]    mem_write_en,
    output logic [`XLEN-1:0]          mem_write_data,
    output logic                      mem_read_en,
    input  logic [`XLEN-1:0]          mem_read_data,
    input  logic                      mem_read_ack,

    output logic                      timeout_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_I   = 2'd0,
        OWN_D   = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    // The forced completion happens in the RD_TIMEOUT-th cycle after the
    // grant; the counter holds the number of ack-less cycles already seen.
    localparam logic [3:0] WAIT_LAST = 4'(RD_TIMEOUT - 1);

    state_t     state, state_next;
    owner_t     owner, owner_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       rr_ptr, rr_ptr_next;
    logic       err_q, err_next;

    logic active;
    logic i_pend, d_pend, dbg_pend;
    logic ack_hit, to_hit, retire;
    logic can_issue;
    logic sel_i, sel_d, sel_dbg;

    // Outputs are gated while either reset is asserted so that nothing is
    // granted or acknowledged during reset, even combinationally.
    assign active   = reset_n & ~sync_reset;

    assign i_pend   = i_re;
    assign d_pend   = d_re | (|d_we);
    assign dbg_pend = dbg_re | (|dbg_we);

    assign ack_hit   = (state == ST_READ) & mem_read_ack;
    assign to_hit    = (state == ST_READ) & ~mem_read_ack & (wait_cnt == WAIT_LAST);
    assign retire    = active & (ack_hit | to_hit);

    // A real ack frees the port in the same cycle; a timeout does not.
    assign can_issue = active & ((state == ST_IDLE) | mem_read_ack);

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
    always_comb begin
        sel_i   = 1'b0;
        sel_d   = 1'b0;
        sel_dbg = 1'b0;
        if (can_issue) begin
            if (dbg_pend) begin
                sel_dbg = 1'b1;
            end else if (i_pend && d_pend) begin
                if (rr_ptr) sel_d = 1'b1;
                else        sel_i = 1'b1;
            end else if (i_pend) begin
                sel_i = 1'b1;
            end else if (d_pend) begin
                sel_d = 1'b1;
            end
        end
    end

    assign i_gnt   = sel_i;
    assign d_gnt   = sel_d;
    assign dbg_gnt = sel_dbg;

    // -------------------------------------------------------------------------
    // Memory command mux
    // -------------------------------------------------------------------------
    always_comb begin
        mem_addr       = '0;
        mem_write_en   = '0;
        mem_write_data = '0;
        mem_read_en    = 1'b0;
        if (sel_dbg) begin
            mem_addr       = dbg_addr;
            mem_write_en   = dbg_we;
            mem_write_data = dbg_wdata;
            mem_read_en    = dbg_re;
        end else if (sel_i) begin
            mem_addr       = i_addr;
            mem_read_en    = 1'b1;
        end else if (sel_d) begin
            mem_addr       = d_addr;
            mem_write_en   = d_we;
            mem_write_data = d_wdata;
            mem_read_en    = d_re;
        end
    end

    // -------------------------------------------------------------------------
    // Read-return steering
    // -------------------------------------------------------------------------
    assign i_rd_ack    = retire & (owner == OWN_I);
    assign d_rd_ack    = retire & (owner == OWN_D);
    assign dbg_rd_ack  = retire & (owner == OWN_DBG);
    assign rd_data     = (active & ack_hit) ? mem_read_data : '0;
    assign timeout_err = err_q;

    // -------------------------------------------------------------------------
    // Read-tracking FSM, next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        wait_cnt_next = wait_cnt;
        rr_ptr_next   = rr_ptr;
        err_next      = err_q;

        case (state)
            ST_IDLE: begin
            end
            ST_READ: begin
                if (mem_read_ack) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A new read grant overrides the retirement of the previous one.
        if (mem_read_en) begin
            state_next    = ST_READ;
            wait_cnt_next = 4'd0;
            if (sel_dbg)    owner_next = OWN_DBG;
            else if (sel_d) owner_next = OWN_D;
            else            owner_next = OWN_I;
        end

        if (sel_i) rr_ptr_next = 1'b1;
        if (sel_d) rr_ptr_next = 1'b0;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            owner    <= OWN_I;
            wait_cnt <= 4'd0;
            rr_ptr   <= RR_INIT;
            err_q    <= 1'b0;
        end else if (sync_reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_I;
            wait_cnt <= 4'd0;
            rr_ptr   <= RR_INIT;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            wait_cnt <= wait_cnt_next;
            rr_ptr   <= rr_ptr_next;
            err_q    <= err_next;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port memory controller (SRAM, 32-bit, byte-lane writes, 1-cycle read ack) among three requesters:
  - instruction fetch (i)
  - load/store unit (d)
  - on-chip debugger (dbg)
- Sits between the core/OCD and the memory controller.
- Arbitration: dbg has fixed top priority; i and d share access round-robin.
- Tracks the owner of the outstanding read, steers the read ack to that owner, and recovers from a missing ack with a timeout.

Parameters:
- RD_TIMEOUT, 4: cycles an outstanding read may wait for mem_read_ack before forced completion (range 1..15).
- RR_INIT, 0: round-robin pointer after reset (0 = i preferred, 1 = d preferred).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous reset, active-low
- sync_reset  input  1  synchronous reset, active-high; same effect as reset_n
- i_addr  input  `MEM_ADDR_BITS  fetch address
- i_re  input  1  fetch read request; held until i_gnt
- i_gnt  output  1  fetch request accepted this cycle
- i_rd_ack  output  1  fetch read data valid on rd_data
- d_addr  input  `MEM_ADDR_BITS  load/store address
- d_we  input  `XLEN_BYTES  byte write enables
- d_wdata  input  `XLEN  write data
- d_re  input  1  load request
- d_gnt  output  1  load/store request accepted this cycle
- d_rd_ack  output  1  load data valid on rd_data
- dbg_addr, dbg_we, dbg_wdata, dbg_re, dbg_gnt, dbg_rd_ack: same widths and meaning as the d_* ports, for the debugger
- rd_data  output  `XLEN  shared read-data return bus
- mem_addr  output  `MEM_ADDR_BITS  to memory controller
- mem_write_en  output  `XLEN_BYTES  to memory controller
- mem_write_data  output  `XLEN  to memory controller
- mem_read_en  output  1  to memory controller
- mem_read_data  input  `XLEN  from memory controller
- mem_read_ack  input  1  from memory controller, one cycle after mem_read_en
- timeout_err  output  1  sticky flag: a read was force-completed

Behaviour:
- Request definition:
  - Requester x is pending when x_re = 1 or |x_we = 1 (i: i_re only).
  - Requesters hold addr/we/wdata/re stable until their gnt.
- Grant is allowed (can_issue) when no read is outstanding, or when mem_read_ack = 1 in the current cycle. Back-to-back reads therefore run at 1 per cycle.
- Winner selection, combinational within the cycle:
  - dbg pending → dbg.
  - Else if both i and d are pending → the side selected by rr_ptr.
  - Else whichever of i/d is pending.
- Grant cycle:
  - Exactly one x_gnt = 1.
  - mem_addr, mem_write_en, mem_write_data, mem_read_en are driven combinationally from the winner.
  - With no grant, mem_write_en = 0 and mem_read_en = 0; mem_addr and mem_write_data are don't-care, but the implementation drives 0.
- rr_ptr:
  - Updates only on an i or d grant, to point at the other side.
  - A dbg grant does not change rr_ptr.
- Read tracking:
  - On a grant with mem_read_en = 1, register owner (2-bit: i/d/dbg), set rd_pending = 1, and clear the wait counter.
  - The next grant overwrites these fields in the same edge that the ack retires the previous read.
- Ack steering:
  - While rd_pending and mem_read_ack = 1, assert owner_rd_ack for 1 cycle and drive rd_data = mem_read_data.
  - Otherwise rd_data = 0.
  - An ack arriving with rd_pending = 0 is ignored.
- Combined access: a request with re = 1 and we ≠ 0 is forwarded as-is. The returned data is the pre-write contents (SRAM read-before-write).
- Write-only grants complete in the grant cycle; there is no ack.
- Timeout:
  - While rd_pending and no ack, the wait counter increments each cycle and grants are blocked.
  - When the counter reaches RD_TIMEOUT: assert owner_rd_ack for 1 cycle with rd_data = 0, clear rd_pending, set timeout_err.
  - timeout_err clears only on reset.
- Reset (reset_n low or sync_reset high, including mid-read):
  - rd_pending = 0, counter = 0, rr_ptr = RR_INIT, timeout_err = 0.
  - All gnt and rd_ack outputs = 0, mem_read_en = 0, mem_write_en = 0.
  - An in-flight read is dropped; a late mem_read_ack is ignored.
- Latency: grant is 0 cycles after a request when idle; read data arrives 1 cycle after the grant.

Test Plan:
- i_re=1 addr 0x10 alone, mem_controller returning 0xDEADBEEF → i_gnt at cycle 0 with mem_read_en=1 and mem_addr=0x10; i_rd_ack=1 and rd_data=0xDEADBEEF at cycle 1.
- i_re and d_re both held for 4 cycles after reset (RR_INIT=0) → grant order i, d, i, d; each rd_ack reaches the matching owner one cycle later.
- dbg write 0x12345678 to 0x20 (we=4'b1111) asserted alongside i_re and d_re → dbg_gnt first with rr_ptr unchanged; next cycle the i/d round-robin resumes; a later read of 0x20 returns 0x12345678.
- d_we=4'b0100 with d_wdata=0xAABBCCDD to a word holding 0 → the word reads back 0x00BB0000; d_gnt pulses exactly 1 cycle and d_rd_ack stays 0.
- Memory model withholds the ack, RD_TIMEOUT=4, d_re → d_gnt; the 4 cycles after the grant show no grants despite i_re=1; d_rd_ack fires with rd_data=0 at the timeout; timeout_err stays 1; i_gnt follows on the next cycle.
- reset_n pulsed low the cycle after an i_re grant → no i_rd_ack, all outputs 0; after release, a new d_re completes normally.
